// File: rtl/vscale_mem_arbiter.sv
// Two-master (fetch/data) arbiter onto one shared memory port. It alternates
// grants on ties, rejects misaligned accesses up front and bounds each access with a timeout.
module vscale_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic        imem_wait,
  output logic [31:0] imem_rdata,
  output logic        imem_badmem_e,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_wait,
  output logic [31:0] dmem_rdata,
  output logic        dmem_badmem_e,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY_I = 3'd1,
    S_BUSY_D = 3'd2,
    S_ERR_I  = 3'd3,
    S_ERR_D  = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_last_d;
  logic [7:0]  r_cnt;
  logic        r_wen;
  logic [2:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic w_busy_i, w_busy_d, w_err_i, w_err_d;
  logic w_tmo, w_done_i, w_done_d;
  logic w_grant_i, w_grant_d;

  function automatic logic f_bad_d(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = addr_lo[0];
      2'd2:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // An access caught by reset is abandoned silently, so gate every completion with reset.
  assign w_busy_i = (r_state == S_BUSY_I) && !reset;
  assign w_busy_d = (r_state == S_BUSY_D) && !reset;
  assign w_err_i  = (r_state == S_ERR_I) && !reset;
  assign w_err_d  = (r_state == S_ERR_D) && !reset;
  assign w_tmo    = (r_cnt == TMO_LAST) && !mem_ready;
  assign w_done_i = w_busy_i && (mem_ready || w_tmo);
  assign w_done_d = w_busy_d && (mem_ready || w_tmo);

  assign imem_wait     = imem_req && !(w_done_i || w_err_i);
  assign imem_rdata    = (w_busy_i && mem_ready) ? mem_rdata : 32'd0;
  assign imem_badmem_e = w_err_i || (w_busy_i && (mem_ready ? mem_error : w_tmo));
  assign dmem_wait     = dmem_en && !(w_done_d || w_err_d);
  assign dmem_rdata    = (w_busy_d && mem_ready) ? mem_rdata : 32'd0;
  assign dmem_badmem_e = w_err_d || (w_busy_d && (mem_ready ? mem_error : w_tmo));

  assign mem_req   = (r_state == S_BUSY_I) || (r_state == S_BUSY_D);
  assign mem_wen   = r_wen;
  assign mem_size  = r_size;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  // Grant decision: fresh arbitration in IDLE, hand-over to the other master on completion.
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dmem_en && (!imem_req || !r_last_d)) begin
          w_grant_d = 1'b1;
        end else if (imem_req) begin
          w_grant_i = 1'b1;
        end else begin
          w_grant_i = 1'b0;
        end
      end
      S_BUSY_I: begin
        if (w_done_i && dmem_en) begin
          w_grant_d = 1'b1;
        end else begin
          w_grant_d = 1'b0;
        end
      end
      S_BUSY_D: begin
        if (w_done_d && imem_req) begin
          w_grant_i = 1'b1;
        end else begin
          w_grant_i = 1'b0;
        end
      end
      default: begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
      end
    endcase
  end

  // Arbiter state, registered access fields and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_last_d <= 1'b0;
      r_cnt    <= 8'd0;
      r_wen    <= 1'b0;
      r_size   <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
    end else if (w_grant_d) begin
      r_wen    <= dmem_wen;
      r_size   <= dmem_size;
      r_addr   <= dmem_addr;
      r_wdata  <= dmem_wdata;
      r_last_d <= 1'b1;
      r_cnt    <= 8'd0;
      r_state  <= f_bad_d(dmem_size[1:0], dmem_addr[1:0]) ? S_ERR_D : S_BUSY_D;
    end else if (w_grant_i) begin
      r_wen    <= 1'b0;
      r_size   <= 3'b010;
      r_addr   <= imem_addr;
      r_wdata  <= 32'd0;
      r_last_d <= 1'b0;
      r_cnt    <= 8'd0;
      r_state  <= (imem_addr[1:0] != 2'b00) ? S_ERR_I : S_BUSY_I;
    end else begin
      case (r_state)
        S_BUSY_I: begin
          if (w_done_i) r_state <= S_IDLE;
          else          r_cnt   <= r_cnt + 8'd1;
        end
        S_BUSY_D: begin
          if (w_done_d) r_state <= S_IDLE;
          else          r_cnt   <= r_cnt + 8'd1;
        end
        S_ERR_I, S_ERR_D: r_state <= S_IDLE;
        default:          r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Bench for vscale_mem_arbiter: directed cycle table, a reset-abort sequence,
// then random traffic checked against a transaction-level reference model.
module tb_vscale_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_wait, imem_badmem_e;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_en, dmem_wen, dmem_wait, dmem_badmem_e;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_req, mem_wen, mem_ready, mem_error;
  logic [2:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  vscale_mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_wait(imem_wait),
    .imem_rdata(imem_rdata), .imem_badmem_e(imem_badmem_e),
    .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wait(dmem_wait),
    .dmem_rdata(dmem_rdata), .dmem_badmem_e(dmem_badmem_e),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [136:0] act;
  assign act = {imem_wait, imem_rdata, imem_badmem_e, dmem_wait, dmem_rdata, dmem_badmem_e,
                mem_req, mem_wen, mem_size, mem_addr, mem_wdata};

  typedef struct {
    logic rst; logic ireq; logic [31:0] iaddr;
    logic den; logic dwen; logic [2:0] dsize; logic [31:0] daddr; logic [31:0] dwdata;
    logic mrdy; logic [31:0] mrdata; logic merr;
    logic [136:0] exp;
  } vec_t;

  vec_t tv [24];

  function automatic logic [136:0] pk(input logic iw, input logic [31:0] ird, input logic ib,
                                      input logic dw, input logic [31:0] drd, input logic db,
                                      input logic mrq, input logic mw, input logic [2:0] ms,
                                      input logic [31:0] ma, input logic [31:0] mwd);
    return {iw, ird, ib, dw, drd, db, mrq, mw, ms, ma, mwd};
  endfunction

  function automatic vec_t mk(input logic rst, input logic ireq, input logic [31:0] iaddr,
                              input logic den, input logic dwen, input logic [2:0] dsize,
                              input logic [31:0] daddr, input logic [31:0] dwdata,
                              input logic mrdy, input logic [31:0] mrdata, input logic merr,
                              input logic [136:0] e);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.den = den; v.dwen = dwen;
    v.dsize = dsize; v.daddr = daddr; v.dwdata = dwdata;
    v.mrdy = mrdy; v.mrdata = mrdata; v.merr = merr; v.exp = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset = v.rst; imem_req = v.ireq; imem_addr = v.iaddr;
    dmem_en = v.den; dmem_wen = v.dwen; dmem_size = v.dsize;
    dmem_addr = v.daddr; dmem_wdata = v.dwdata;
    mem_ready = v.mrdy; mem_rdata = v.mrdata; mem_error = v.merr;
  endtask

  task automatic check(input string nm, input logic [136:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, e);
    end
  endtask

  task automatic check_w(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  // Reference model: who owns the port, whether that access is a rejected one, and its age.
  int          m_owner;   // 0 none, 1 fetch, 2 data
  bit          m_bad;
  int          m_age;
  bit          m_last_d;
  logic        m_wen;
  logic [2:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic [136:0] m_exp;
  bit          e_iwait, e_dwait;

  function automatic bit misaligned(input logic [2:0] size, input logic [31:0] addr);
    int bytes;
    if (size[1:0] == 2'd3) return 1'b1;
    bytes = 1 << size[1:0];
    return (addr % bytes) != 0;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_bad = 0; m_age = 0; m_last_d = 0;
    m_wen = 1'b0; m_size = 3'd0; m_addr = 32'd0; m_wdata = 32'd0;
  endtask

  task automatic grant(input int who);
    m_owner = who; m_age = 0; m_last_d = (who == 2);
    if (who == 1) begin
      m_wen = 1'b0; m_size = 3'd2; m_addr = imem_addr; m_wdata = 32'd0;
      m_bad = (imem_addr % 4) != 0;
    end else begin
      m_wen = dmem_wen; m_size = dmem_size; m_addr = dmem_addr; m_wdata = dmem_wdata;
      m_bad = misaligned(dmem_size, dmem_addr);
    end
  endtask

  task automatic model_step();
    bit done, tmo;
    logic [31:0] e_ird, e_drd;
    logic e_ib, e_db;
    tmo  = (m_age == TMO - 1);
    done = !reset && m_owner != 0 && (m_bad || mem_ready || tmo);
    e_iwait = imem_req && !(done && m_owner == 1);
    e_dwait = dmem_en && !(done && m_owner == 2);
    e_ird = (done && m_owner == 1 && !m_bad && mem_ready) ? mem_rdata : 32'd0;
    e_drd = (done && m_owner == 2 && !m_bad && mem_ready) ? mem_rdata : 32'd0;
    e_ib  = done && m_owner == 1 && (m_bad || !mem_ready || mem_error);
    e_db  = done && m_owner == 2 && (m_bad || !mem_ready || mem_error);
    m_exp = pk(e_iwait, e_ird, e_ib, e_dwait, e_drd, e_db, (m_owner != 0) && !m_bad,
               m_wen, m_size, m_addr, m_wdata);
    if (reset) model_reset();
    else if (m_owner == 0) begin
      if (dmem_en && (!imem_req || !m_last_d)) grant(2);
      else if (imem_req) grant(1);
    end else if (done) begin
      if (!m_bad && m_owner == 1 && dmem_en) grant(2);
      else if (!m_bad && m_owner == 2 && imem_req) grant(1);
      else m_owner = 0;
    end else m_age++;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  bit          i_act, d_act;
  logic [31:0] i_a, d_a, d_wd;
  logic [2:0]  d_sz;
  logic        d_w;

  initial begin
    // Cycle-by-cycle directed scenarios (timeout of 4 cycles).
    tv[0]  = mk(0, 1,32'h100, 0,0,3'd0,32'h0,32'h0, 0,32'h0,0,        pk(1,32'h0,0, 0,32'h0,0, 0,0,3'd0,32'h0,32'h0));
    tv[1]  = mk(0, 1,32'h100, 0,0,3'd0,32'h0,32'h0, 0,32'h0,0,        pk(1,32'h0,0, 0,32'h0,0, 1,0,3'd2,32'h100,32'h0));
    tv[2]  = mk(0, 1,32'h100, 0,0,3'd0,32'h0,32'h0, 1,32'hDEADBEEF,0, pk(0,32'hDEADBEEF,0, 0,32'h0,0, 1,0,3'd2,32'h100,32'h0));
    tv[3]  = mk(0, 0,32'h0,   0,0,3'd0,32'h0,32'h0, 0,32'h0,0,        pk(0,32'h0,0, 0,32'h0,0, 0,0,3'd2,32'h100,32'h0));
    tv[4]  = mk(0, 1,32'h300, 1,0,3'd2,32'h200,32'h0, 0,32'h0,0,      pk(1,32'h0,0, 1,32'h0,0, 0,0,3'd2,32'h100,32'h0));
    tv[5]  = mk(0, 1,32'h300, 1,0,3'd2,32'h200,32'h0, 0,32'h0,0,      pk(1,32'h0,0, 1,32'h0,0, 1,0,3'd2,32'h200,32'h0));
    tv[6]  = mk(0, 1,32'h300, 1,0,3'd2,32'h200,32'h0, 1,32'h11112222,0, pk(1,32'h0,0, 0,32'h11112222,0, 1,0,3'd2,32'h200,32'h0));
    tv[7]  = mk(0, 1,32'h300, 0,0,3'd0,32'h0,32'h0, 1,32'h33334444,0, pk(0,32'h33334444,0, 0,32'h0,0, 1,0,3'd2,32'h300,32'h0));
    tv[8]  = mk(0, 0,32'h0,   1,1,3'd2,32'h400,32'hCAFE, 0,32'h0,0,   pk(0,32'h0,0, 1,32'h0,0, 0,0,3'd2,32'h300,32'h0));
    tv[9]  = mk(0, 0,32'h0,   1,1,3'd2,32'h400,32'hCAFE, 1,32'h55,1,  pk(0,32'h0,0, 0,32'h55,1, 1,1,3'd2,32'h400,32'hCAFE));
    tv[10] = mk(0, 1,32'h500, 1,0,3'd2,32'h600,32'h0, 0,32'h0,0,      pk(1,32'h0,0, 1,32'h0,0, 0,1,3'd2,32'h400,32'hCAFE));
    tv[11] = mk(0, 1,32'h500, 1,0,3'd2,32'h600,32'h0, 1,32'h77,0,     pk(0,32'h77,0, 1,32'h0,0, 1,0,3'd2,32'h500,32'h0));
    tv[12] = mk(0, 0,32'h0,   1,0,3'd2,32'h600,32'h0, 1,32'h88,0,     pk(0,32'h0,0, 0,32'h88,0, 1,0,3'd2,32'h600,32'h0));
    tv[13] = mk(0, 0,32'h0,   1,0,3'd2,32'h202,32'h0, 0,32'h0,0,      pk(0,32'h0,0, 1,32'h0,0, 0,0,3'd2,32'h600,32'h0));
    tv[14] = mk(0, 0,32'h0,   1,0,3'd2,32'h202,32'h0, 1,32'h99,0,     pk(0,32'h0,0, 0,32'h0,1, 0,0,3'd2,32'h202,32'h0));
    tv[15] = mk(0, 1,32'h102, 0,0,3'd0,32'h0,32'h0, 0,32'h0,0,        pk(1,32'h0,0, 0,32'h0,0, 0,0,3'd2,32'h202,32'h0));
    tv[16] = mk(0, 1,32'h102, 0,0,3'd0,32'h0,32'h0, 0,32'h0,0,        pk(0,32'h0,1, 0,32'h0,0, 0,0,3'd2,32'h102,32'h0));
    tv[17] = mk(0, 0,32'h0,   0,0,3'd0,32'h0,32'h0, 0,32'h0,0,        pk(0,32'h0,0, 0,32'h0,0, 0,0,3'd2,32'h102,32'h0));
    tv[18] = mk(0, 0,32'h0,   1,0,3'd1,32'h7FE,32'h0, 0,32'h0,0,      pk(0,32'h0,0, 1,32'h0,0, 0,0,3'd2,32'h102,32'h0));
    tv[19] = mk(0, 0,32'h0,   1,0,3'd1,32'h7FE,32'h0, 0,32'h0,0,      pk(0,32'h0,0, 1,32'h0,0, 1,0,3'd1,32'h7FE,32'h0));
    tv[20] = tv[19];
    tv[21] = tv[19];
    tv[22] = mk(0, 0,32'h0,   1,0,3'd1,32'h7FE,32'h0, 0,32'h1234,0,   pk(0,32'h0,0, 0,32'h0,1, 1,0,3'd1,32'h7FE,32'h0));
    tv[23] = mk(0, 0,32'h0,   0,0,3'd0,32'h0,32'h0, 0,32'h0,0,        pk(0,32'h0,0, 0,32'h0,0, 0,0,3'd1,32'h7FE,32'h0));

    drive(mk(1, 0,32'h0, 0,0,3'd0,32'h0,32'h0, 0,32'h0,0, '0));
    @(negedge clk); #1;
    check("reset_state", pk(0,32'h0,0, 0,32'h0,0, 0,0,3'd0,32'h0,32'h0));

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      check($sformatf("vec[%0d]", i), tv[i].exp);
    end

    // Reset in the middle of a fetch: the access disappears, a late ready is ignored.
    @(negedge clk);
    drive(mk(0, 1,32'h40, 0,0,3'd0,32'h0,32'h0, 0,32'h0,0, '0));
    @(negedge clk); #1;
    check_w("abort_busy_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hAAAA_AAAA;
    #1;
    check_w("abort_rst_rdata", imem_rdata, 32'd0);
    check_w("abort_rst_bad", {31'd0, imem_badmem_e}, 32'd0);
    @(negedge clk);
    drive(mk(0, 0,32'h0, 0,0,3'd0,32'h0,32'h0, 1,32'hBBBB_BBBB,0, '0));
    #1;
    check("abort_after", pk(0,32'h0,0, 0,32'h0,0, 0,0,3'd0,32'h0,32'h0));

    // Random traffic against the reference model.
    model_reset();
    i_act = 0; d_act = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1; i_a = rnd_addr();
      end
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1; d_a = rnd_addr(); d_sz = 3'($urandom_range(0, 7));
        d_w = 1'($urandom_range(0, 1)); d_wd = $urandom;
      end
      reset      = ($urandom_range(0, 149) == 0);
      imem_req   = i_act;
      imem_addr  = i_act ? i_a : $urandom;
      dmem_en    = d_act;
      dmem_wen   = d_act ? d_w : 1'b0;
      dmem_size  = d_act ? d_sz : 3'd0;
      dmem_addr  = d_act ? d_a : $urandom;
      dmem_wdata = d_act ? d_wd : 32'd0;
      mem_ready  = ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom;
      mem_error  = ($urandom_range(0, 3) == 0);
      #1;
      model_step();
      check($sformatf("rand[%0d]", n), m_exp);
      if (i_act && !e_iwait) i_act = 0;
      if (d_act && !e_dwait) d_act = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
